// File: rtl/link_rst_req_module_if.sv
// Link reset-request status bundle: PCS lock in, reset request / ready / retry count out.
// The slave modport is the one taken by link_rst_req_module.
interface link_rst_req_if;
  logic       i_lock;
  logic       o_rst_req;
  logic       o_ready;
  logic [7:0] o_retry_cnt;

  modport slave (
    input  i_lock,
    output o_rst_req,
    output o_ready,
    output o_retry_cnt
  );

  modport master (
    output i_lock,
    input  o_rst_req,
    input  o_ready,
    input  o_retry_cnt
  );
endinterface

// File: rtl/link_rst_req_module.sv
// Issues reset requests while the link is down and flags ready once block lock is stable.
// Define LINK_RST_SYNC_EN to pass i_lock through a 2-flop synchronizer first.
module link_rst_req_module #(
  parameter int unsigned P_REQ_CYCLE = 4,
  parameter int unsigned P_TIMEOUT   = 1000,
  parameter int unsigned P_STABLE    = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  link_rst_req_if.slave link
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StReady} state_e;

  localparam bit          ReqEn       = (P_REQ_CYCLE != 0);
  localparam logic [15:0] ReqLast     = ReqEn ? 16'(P_REQ_CYCLE - 1) : 16'd0;
  localparam logic [15:0] TimeoutLast = 16'(P_TIMEOUT - 1);
  localparam logic [15:0] StableLast  = 16'(P_STABLE - 1);

  logic lock;

`ifdef LINK_RST_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], link.i_lock};
    end
  end

  assign lock = sync_q[1];
`else
  assign lock = link.i_lock;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic        req_q, req_d;
  logic        ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    retry_d = retry_q;

    unique case (state_q)
      StReq: begin
        if (!ReqEn || (cnt_q == ReqLast)) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Lock arriving on the timeout cycle wins over the retry.
        if (lock) begin
          state_d = StHold;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StReq;
          if (retry_q != 8'hff) begin
            retry_d = retry_q + 8'd1;
          end
        end
      end
      StHold: begin
        if (!lock) begin
          state_d = StWait;
        end else if (cnt_q == StableLast) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (!lock) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StReq;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end

    // Request lags REQ entry by one clock so the pulse spans exactly P_REQ_CYCLE clocks.
    req_d   = ReqEn && (state_q == StReq);
    ready_d = (state_d == StReady);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StReq;
      cnt_q   <= 16'd0;
      retry_q <= 8'd0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      req_q   <= req_d;
      ready_q <= ready_d;
    end
  end

  assign link.o_rst_req   = req_q;
  assign link.o_ready     = ready_q;
  assign link.o_retry_cnt = retry_q;

endmodule
